multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style FSM that sequences the multicycle MIPS datapath (shared memory, IR, A/B, ALUOut, MDR) over 3–5 cycles per instruction.
- Supported opcodes: R-type, lw, sw, beq, bne, j, addi and andi.
- Sits between the IR opcode field and the datapath mux/enable controls.
- Adds a memory-ready handshake so fetch and data accesses can stall.

Parameters:
USE_MEM_READY, 1, 1: honour mem_ready; 0: mem_ready treated as constant 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
opcode  input  6  IR[31:26]; datapath holds it stable from the cycle after FETCH completes
mem_ready  input  1  memory access completes this cycle
IorD  output  1  0 = PC address, 1 = ALUOut address
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  load IR (and MDR)
RegDst  output  1  1 = rd, 0 = rt
MemtoReg  output  1  1 = MDR, 0 = ALUOut to register file
RegWrite  output  1  register file write
ALUSrcA  output  1  0 = PC, 1 = A
ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
ALUOp  output  2  00 = add, 01 = sub, 10 = funct, 11 = and
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
PCWrite  output  1  unconditional PC write
Branch  output  1  PC write if ALU zero (beq)
BranchNe  output  1  PC write if ALU not zero (bne)
illegal_op  output  1  unsupported opcode seen in DECODE
instr_done  output  1  last cycle of an instruction
state  output  4  current state encoding, for debug

Behaviour:
- Reset: state <= FETCH (async). While rst=1, every output except state is forced to 0 and state reads 0.
- Outputs not listed for a state are 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ANDIEX 11, IWB 12. Codes 13–15 go to FETCH on the next edge with all outputs 0.
- FETCH: MemRead=1, ALUSrcB=01. IRWrite=PCWrite=mem_ready (Mealy gate). Stays in FETCH while mem_ready=0; goes to DECODE when it is 1.
- DECODE: ALUSrcB=11 (branch target into ALUOut). Next state by opcode:
  - 0x00 -> EXEC
  - 0x23 or 0x2b -> MEMADR
  - 0x04 or 0x05 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> ADDIEX
  - 0x0c -> ANDIEX
  - any other -> FETCH, with illegal_op=1 and instr_done=1 in this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10. Goes to MEMRD if opcode=0x23, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Held until mem_ready=1, then MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1, instr_done=1. -> FETCH.
- MEMWR: MemWrite=1, IorD=1. Held until mem_ready; instr_done=mem_ready; then FETCH.
- EXEC: ALUSrcA=1, ALUOp=10. -> RWB.
- RWB: RegDst=1, RegWrite=1, instr_done=1. -> FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01, Branch=(opcode==0x04), BranchNe=(opcode==0x05), instr_done=1. -> FETCH.
- JUMP: PCSource=10, PCWrite=1, instr_done=1. -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> IWB.
- ANDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=11. -> IWB.
- IWB: RegWrite=1, instr_done=1. -> FETCH.
- Latency with no stalls: R/addi/andi/sw = 4 cycles, lw = 5, beq/bne/j = 3. Each mem_ready=0 cycle adds 1.
- Mutual exclusion:
  - MemRead and MemWrite are never both 1.
  - Branch and BranchNe are never both 1.
  - IRWrite=1 only in FETCH.
- Reset mid-instruction: the current access is abandoned immediately (outputs 0 in the same cycle). After release, execution resumes in FETCH. No partial RegWrite or MemWrite is issued.

Test Plan:
- lw (opcode 0x23), mem_ready=1 throughout -> states 0,1,2,3,4; RegWrite=1 and MemtoReg=1 only in cycle 5; instr_done pulses once; total 5 cycles.
- R-type with mem_ready=0 for 2 FETCH cycles -> FETCH held 3 cycles with MemRead=1; IRWrite/PCWrite high only in the 3rd cycle; then 1,6,7; RegDst=1 in RWB.
- beq (0x04) then bne (0x05) -> BRANCH cycle shows Branch=1/BranchNe=0, then 0/1; PCSource=01, ALUOp=01; 3 cycles each.
- sw (0x2b) with mem_ready low for 1 cycle in MEMWR -> MemWrite=1 for 2 cycles; instr_done only on the 2nd; RegWrite never 1.
- Opcode 0x3f -> DECODE asserts illegal_op=1 and instr_done=1 for one cycle; next state FETCH; no RegWrite/MemWrite/PCWrite.
- rst asserted asynchronously during MEMRD -> all outputs 0 within the same cycle, state=0. After release, FETCH with MemRead=1. j (0x02) afterwards -> JUMP with PCWrite=1 and PCSource=10.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences shared memory, IR, A/B, ALUOut and MDR
// over 3-5 cycles per instruction, stalling on a memory-ready handshake.
module multicycle_control #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       Branch,
  output logic       BranchNe,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  localparam int unsigned OPW = 6;
  localparam int unsigned SW  = 4;

  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_J     = 6'h02;
  localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPW-1:0] OP_BNE   = 6'h05;
  localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPW-1:0] OP_ANDI  = 6'h0c;
  localparam logic [OPW-1:0] OP_LW    = 6'h23;
  localparam logic [OPW-1:0] OP_SW    = 6'h2b;

  typedef enum logic [SW-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ANDIEX = 4'd11,
    S_IWB    = 4'd12
  } state_t;

  state_t state_r;
  state_t state_nxt;
  logic   ready;

  // With the handshake disabled every memory access completes in one cycle.
  assign ready = USE_MEM_READY ? mem_ready : 1'b1;

  // Debug view of the state; reads 0 while reset is held.
  assign state = rst ? '0 : SW'(state_r);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_FETCH;
    else     state_r <= state_nxt;
  end

  // Next-state and datapath controls; everything is forced low during reset.
  always_comb begin
    state_nxt  = state_r;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSource   = 2'b00;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    BranchNe   = 1'b0;
    illegal_op = 1'b0;
    instr_done = 1'b0;

    case (state_r)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = ready;
        PCWrite = ready;
        if (ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_ANDI:      state_nxt = S_ANDIEX;
          default: begin
            state_nxt  = S_FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = ready;
        if (ready) state_nxt = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        state_nxt = S_RWB;
      end
      S_RWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSource   = 2'b01;
        Branch     = (opcode == OP_BEQ);
        BranchNe   = (opcode == OP_BNE);
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUOp     = 2'b00;
        state_nxt = S_IWB;
      end
      S_ANDIEX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUOp     = 2'b11;
        state_nxt = S_IWB;
      end
      S_IWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase

    if (rst) begin
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      PCSource   = 2'b00;
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      BranchNe   = 1'b0;
      illegal_op = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, hand-written
// reset/jump sequence, then randomized instructions against a path-based model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       PCWrite, Branch, BranchNe, illegal_op, instr_done;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .PCWrite(PCWrite),
    .Branch(Branch), .BranchNe(BranchNe), .illegal_op(illegal_op),
    .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsource;
    logic       pcwrite, branch, branchne, illegal, done;
    logic [3:0] st;
  } outs_t;

  outs_t act;
  assign act = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSource, PCWrite, Branch, BranchNe, illegal_op,
                instr_done, state};

  // Directed vector: inputs plus expected state and flags
  // {MemRead,MemWrite,IRWrite,RegWrite,PCWrite,Branch,BranchNe,illegal_op,instr_done}.
  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic [8:0] fl;
  } vec_t;

  function automatic vec_t v(input logic [5:0] op, input logic rdy,
                             input logic [3:0] st, input logic [8:0] fl);
    vec_t r;
    r.op = op; r.rdy = rdy; r.st = st; r.fl = fl;
    return r;
  endfunction

  function automatic logic [12:0] key(input outs_t o);
    return {o.st, o.memread, o.memwrite, o.irwrite, o.regwrite, o.pcwrite,
            o.branch, o.branchne, o.illegal, o.done};
  endfunction

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  // Drive inputs just after the rising edge, then wait for the sample point.
  task automatic step(input logic [5:0] op, input logic rdy);
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = rdy;
    @(negedge clk);
  endtask

  // Reference: controls each cycle from the state's role in the instruction.
  function automatic outs_t exp_out(input int code, input logic [5:0] op, input logic rdy);
    outs_t o = '0;
    o.st = 4'(code);
    case (code)
      0:  begin o.memread = 1; o.alusrcb = 2'b01; o.irwrite = rdy; o.pcwrite = rdy; end
      1:  begin
            o.alusrcb = 2'b11;
            if (!(op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0c})) begin
              o.illegal = 1; o.done = 1;
            end
          end
      2:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      3:  begin o.memread = 1; o.iord = 1; end
      4:  begin o.memtoreg = 1; o.regwrite = 1; o.done = 1; end
      5:  begin o.memwrite = 1; o.iord = 1; o.done = rdy; end
      6:  begin o.alusrca = 1; o.aluop = 2'b10; end
      7:  begin o.regdst = 1; o.regwrite = 1; o.done = 1; end
      8:  begin
            o.alusrca = 1; o.aluop = 2'b01; o.pcsource = 2'b01; o.done = 1;
            o.branch = (op == 6'h04); o.branchne = (op == 6'h05);
          end
      9:  begin o.pcsource = 2'b10; o.pcwrite = 1; o.done = 1; end
      10: begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluop = 2'b00; end
      11: begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluop = 2'b11; end
      12: begin o.regwrite = 1; o.done = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Reference: the sequence of states an instruction walks through (stalls excluded).
  function automatic void build_path(input logic [5:0] op, output int p[$]);
    p = {0, 1};
    case (op)
      6'h23: p = {p, 2, 3, 4};
      6'h2b: p = {p, 2, 5};
      6'h00: p = {p, 6, 7};
      6'h04, 6'h05: p.push_back(8);
      6'h02: p.push_back(9);
      6'h08: p = {p, 10, 12};
      6'h0c: p = {p, 11, 12};
      default: ;
    endcase
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] legal [8] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0c};
    if ($urandom_range(0, 4) == 0) return 6'($urandom_range(0, 63));
    return legal[$urandom_range(0, 7)];
  endfunction

  vec_t tbl[$];

  initial begin
    int         path[$];
    int         idx;
    logic [5:0] cur_op;
    logic       rdy;
    logic       do_rst;
    outs_t      e;

    rst = 1'b1; opcode = 6'h00; mem_ready = 1'b0;

    tbl.push_back(v(6'h23, 1, 0, 9'b101010000));   // lw
    tbl.push_back(v(6'h23, 1, 1, 9'b000000000));
    tbl.push_back(v(6'h23, 1, 2, 9'b000000000));
    tbl.push_back(v(6'h23, 1, 3, 9'b100000000));
    tbl.push_back(v(6'h23, 1, 4, 9'b000100001));
    tbl.push_back(v(6'h00, 0, 0, 9'b100000000));   // R-type, fetch stalled twice
    tbl.push_back(v(6'h00, 0, 0, 9'b100000000));
    tbl.push_back(v(6'h00, 1, 0, 9'b101010000));
    tbl.push_back(v(6'h00, 1, 1, 9'b000000000));
    tbl.push_back(v(6'h00, 1, 6, 9'b000000000));
    tbl.push_back(v(6'h00, 1, 7, 9'b000100001));
    tbl.push_back(v(6'h04, 1, 0, 9'b101010000));   // beq
    tbl.push_back(v(6'h04, 1, 1, 9'b000000000));
    tbl.push_back(v(6'h04, 1, 8, 9'b000001001));
    tbl.push_back(v(6'h05, 1, 0, 9'b101010000));   // bne
    tbl.push_back(v(6'h05, 1, 1, 9'b000000000));
    tbl.push_back(v(6'h05, 1, 8, 9'b000000101));
    tbl.push_back(v(6'h2b, 1, 0, 9'b101010000));   // sw, one stall in MEMWR
    tbl.push_back(v(6'h2b, 1, 1, 9'b000000000));
    tbl.push_back(v(6'h2b, 1, 2, 9'b000000000));
    tbl.push_back(v(6'h2b, 0, 5, 9'b010000000));
    tbl.push_back(v(6'h2b, 1, 5, 9'b010000001));
    tbl.push_back(v(6'h3f, 1, 0, 9'b101010000));   // illegal opcode
    tbl.push_back(v(6'h3f, 1, 1, 9'b000000011));

    #2;
    check("reset_outputs_zero", 32'(act), 32'd0);
    @(posedge clk); #1;
    check("reset_held_zero", 32'(act), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_fetch", 32'(key(act)), 32'({4'd0, 9'b100000000}));

    foreach (tbl[i]) begin
      step(tbl[i].op, tbl[i].rdy);
      check($sformatf("vec%0d_op%h_st%0d", i, tbl[i].op, tbl[i].st),
            32'(key(act)), 32'({tbl[i].st, tbl[i].fl}));
    end
    check("lw_memtoreg_in_memwb_only", 32'(MemtoReg), 32'd0);

    // Asynchronous reset while a load waits in MEMRD, then a jump.
    step(6'h23, 1); step(6'h23, 1); step(6'h23, 1);
    step(6'h23, 0);
    check("rst_pre_memrd", 32'(key(act)), 32'({4'd3, 9'b100000000}));
    #2 rst = 1'b1;
    #1 check("rst_async_zero", 32'(act), 32'd0);
    @(posedge clk); #1;
    check("rst_across_edge_zero", 32'(act), 32'd0);
    rst = 1'b0; opcode = 6'h02; mem_ready = 1'b1;
    @(negedge clk);
    check("rst_release_fetch", 32'(key(act)), 32'({4'd0, 9'b101010000}));
    step(6'h02, 1);
    check("j_decode_state", 32'(state), 32'd1);
    step(6'h02, 1);
    check("j_jump", 32'({state, PCSource, PCWrite, instr_done, RegWrite, MemWrite}),
          32'({4'd9, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0}));

    // Randomized instructions and stalls, with occasional mid-instruction reset.
    cur_op = pick_op();
    build_path(cur_op, path);
    idx = 0;
    for (int c = 0; c < 600; c++) begin
      rdy    = ($urandom_range(0, 3) != 0);
      do_rst = ($urandom_range(0, 49) == 0);
      @(posedge clk); #1;
      opcode = cur_op; mem_ready = rdy; rst = do_rst;
      @(negedge clk);
      if (do_rst) begin
        check($sformatf("rand%0d_reset", c), 32'(act), 32'd0);
        cur_op = pick_op();
        build_path(cur_op, path);
        idx = 0;
      end else begin
        e = exp_out(path[idx], cur_op, rdy);
        check($sformatf("rand%0d_op%h_st%0d", c, cur_op, path[idx]), 32'(act), 32'(e));
        if (!((path[idx] inside {0, 3, 5}) && !rdy)) idx++;
        if (idx >= path.size()) begin
          cur_op = pick_op();
          build_path(cur_op, path);
          idx = 0;
        end
      end
    end
    @(posedge clk); #1 rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
